hazard_forward_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/fwd_select.sv | 27 ++
 rtl/hazard_forward_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_forward_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

  // Operand mux select encoding for the EX-stage operand muxes.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_RET = 2'b11
  } fwd_sel_e;

  // Destination part of a tag; the only part that travels past EX.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
  } dst_tag_t;

  // Full EX-stage tag: destination info plus the operand sources it consumes.
  typedef struct packed {
    dst_tag_t         dst;
    logic             memread;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             uses1;
    logic             uses2;
  } stage_tag_t;

  // A stage produces register r when it will write a non-zero r.
  function automatic logic produces(input dst_tag_t t, input logic [REG_W-1:0] r);
    return t.valid && t.regwrite && (t.rd == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX-stage source operand.
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             uses,
  input  dst_tag_t         mem_tag,
  input  dst_tag_t         wb_tag,
  input  dst_tag_t         ret_tag,
  output fwd_sel_e         sel_c
);

  // Youngest producer wins: MEM, then WB, then RET, else the register file.
  always_comb begin
    sel_c = FWD_RF;
    if (uses) begin
      if (produces(mem_tag, src)) begin
        sel_c = FWD_MEM;
      end else if (produces(wb_tag, src)) begin
        sel_c = FWD_WB;
      end else if (produces(ret_tag, src)) begin
        sel_c = FWD_RET;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection, operand forwarding and stall/flush event counting
// for the 5-stage core.
module hazard_forward_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_Valid,
  input  logic [REG_W-1:0] ID_Rs1,
  input  logic [REG_W-1:0] ID_Rs2,
  input  logic [REG_W-1:0] ID_Rd,
  input  logic             ID_UsesRs1,
  input  logic             ID_UsesRs2,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             EX_BranchTaken,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             Stall,
  output logic             FlushIF_ID,
  output logic             FlushID_EX,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  stage_tag_t ex_q;
  dst_tag_t   mem_q;
  dst_tag_t   wb_q;
  dst_tag_t   ret_q;
  stage_tag_t id_tag_c;
  logic       load_use_c;
  fwd_sel_e   fwd_a_c;
  fwd_sel_e   fwd_b_c;

  // Tag for the instruction in ID; all-zero (bubble) when ID is empty.
  always_comb begin
    id_tag_c = '0;
    if (ID_Valid) begin
      id_tag_c.dst.valid    = 1'b1;
      id_tag_c.dst.rd       = ID_Rd;
      id_tag_c.dst.regwrite = ID_RegWrite;
      id_tag_c.memread      = ID_MemRead;
      id_tag_c.rs1          = ID_Rs1;
      id_tag_c.rs2          = ID_Rs2;
      id_tag_c.uses1        = ID_UsesRs1;
      id_tag_c.uses2        = ID_UsesRs2;
    end
  end

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use_c = 1'b0;
    if (ID_Valid && ex_q.dst.valid && ex_q.memread && (ex_q.dst.rd != REG_ZERO)) begin
      load_use_c = (ID_UsesRs1 && (ID_Rs1 == ex_q.dst.rd)) ||
                   (ID_UsesRs2 && (ID_Rs2 == ex_q.dst.rd));
    end
  end

  // A taken branch squashes the younger instructions and overrides any stall.
  always_comb begin
    Stall      = load_use_c && !EX_BranchTaken;
    FlushIF_ID = EX_BranchTaken;
    FlushID_EX = EX_BranchTaken;
  end

  // Tag pipeline and saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      ret_q      <= '0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      ret_q <= wb_q;
      wb_q  <= mem_q;
      mem_q <= ex_q.dst;
      if (ID_Valid && !Stall && !EX_BranchTaken) begin
        ex_q <= id_tag_c;
      end else begin
        ex_q <= '0;
      end
      if (Stall && (StallCount != '1)) begin
        StallCount <= StallCount + CNT_W'(1);
      end
      if (EX_BranchTaken && (FlushCount != '1)) begin
        FlushCount <= FlushCount + CNT_W'(1);
      end
    end
  end

  fwd_select u_fwd_a (
    .src     (ex_q.rs1),
    .uses    (ex_q.dst.valid && ex_q.uses1),
    .mem_tag (mem_q),
    .wb_tag  (wb_q),
    .ret_tag (ret_q),
    .sel_c   (fwd_a_c)
  );

  fwd_select u_fwd_b (
    .src     (ex_q.rs2),
    .uses    (ex_q.dst.valid && ex_q.uses2),
    .mem_tag (mem_q),
    .wb_tag  (wb_q),
    .ret_tag (ret_q),
    .sel_c   (fwd_b_c)
  );

  // Forward selects depend only on the tag flops.
  always_comb begin
    ForwardA = fwd_a_c;
    ForwardB = fwd_b_c;
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl with 4-bit event counters.
module tb_hazard_forward_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ID_Valid;
  logic [4:0]       ID_Rs1, ID_Rs2, ID_Rd;
  logic             ID_UsesRs1, ID_UsesRs2, ID_RegWrite, ID_MemRead;
  logic             EX_BranchTaken;
  logic [1:0]       ForwardA, ForwardB;
  logic             Stall, FlushIF_ID, FlushID_EX;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int errors = 0;
  int checks = 0;

  hazard_forward_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ID_Valid       (ID_Valid),
    .ID_Rs1         (ID_Rs1),
    .ID_Rs2         (ID_Rs2),
    .ID_Rd          (ID_Rd),
    .ID_UsesRs1     (ID_UsesRs1),
    .ID_UsesRs2     (ID_UsesRs2),
    .ID_RegWrite    (ID_RegWrite),
    .ID_MemRead     (ID_MemRead),
    .EX_BranchTaken (EX_BranchTaken),
    .ForwardA       (ForwardA),
    .ForwardB       (ForwardB),
    .Stall          (Stall),
    .FlushIF_ID     (FlushIF_ID),
    .FlushID_EX     (FlushID_EX),
    .StallCount     (StallCount),
    .FlushCount     (FlushCount)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic rw, input logic mr);
    ID_Valid    = v;
    ID_Rs1      = rs1;
    ID_Rs2      = rs2;
    ID_Rd       = rd;
    ID_UsesRs1  = u1;
    ID_UsesRs2  = u2;
    ID_RegWrite = rw;
    ID_MemRead  = mr;
  endtask

  task automatic nop;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Producer of r, then d-1 bubbles, then a consumer of r on both operands.
  task automatic fwd_dist(input int d, input logic [4:0] r, input logic [1:0] exp, input string tag);
    drive(1'b1, 5'd1, 5'd2, r, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    for (int i = 1; i < d; i++) begin
      nop;
      tick;
    end
    drive(1'b1, r, r, 5'd20, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    nop;
    #1;
    chk({tag, "_a"}, 32'(ForwardA), 32'(exp));
    chk({tag, "_b"}, 32'(ForwardB), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    EX_BranchTaken = 1'b0;
    nop;
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_fwda",   32'(ForwardA),   32'd0);
    chk("rst_fwdb",   32'(ForwardB),   32'd0);
    chk("rst_stall",  32'(Stall),      32'd0);
    chk("rst_flush1", 32'(FlushIF_ID), 32'd0);
    chk("rst_flush2", 32'(FlushID_EX), 32'd0);
    chk("rst_scnt",   32'(StallCount), 32'd0);
    chk("rst_fcnt",   32'(FlushCount), 32'd0);

    // add x5,x1,x2 ; sub x6,x5,x1
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("b2b_stall0", 32'(Stall), 32'd0);
    tick;
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("b2b_stall1", 32'(Stall), 32'd0);
    tick;
    nop;
    #1;
    chk("b2b_fwda", 32'(ForwardA), 32'd2);
    chk("b2b_fwdb", 32'(ForwardB), 32'd0);

    fwd_dist(1, 5'd9,  2'b10, "dist1");
    fwd_dist(2, 5'd10, 2'b01, "dist2");
    fwd_dist(3, 5'd11, 2'b11, "dist3");
    fwd_dist(4, 5'd12, 2'b00, "dist4");

    // lw x7 ; add x8,x7,x7
    tick;
    drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("lu_stall0", 32'(Stall), 32'd0);
    tick;
    drive(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("lu_stall1", 32'(Stall),      32'd1);
    chk("lu_scnt0",  32'(StallCount), 32'd0);
    tick;
    #1;
    chk("lu_stall2", 32'(Stall),      32'd0);
    chk("lu_scnt1",  32'(StallCount), 32'd1);
    tick;
    nop;
    #1;
    chk("lu_fwda", 32'(ForwardA), 32'd1);
    chk("lu_fwdb", 32'(ForwardB), 32'd1);

    // load to x0 followed by a reader of x0
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick;
    drive(1'b1, 5'd0, 5'd0, 5'd21, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("x0_stall", 32'(Stall), 32'd0);
    tick;
    // lw x13 ; consumer has rs2=x13 but does not read rs2
    drive(1'b1, 5'd1, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("x0_fwda", 32'(ForwardA), 32'd0);
    chk("x0_fwdb", 32'(ForwardB), 32'd0);
    tick;
    drive(1'b1, 5'd2, 5'd13, 5'd22, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("unused_stall", 32'(Stall), 32'd0);
    tick;
    nop;
    #1;
    chk("unused_fwda", 32'(ForwardA), 32'd0);
    chk("unused_fwdb", 32'(ForwardB), 32'd0);

    // taken branch while a load-use hazard is present
    drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    tick;
    drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    EX_BranchTaken = 1'b1;
    #1;
    chk("br_stall",  32'(Stall),      32'd0);
    chk("br_flush1", 32'(FlushIF_ID), 32'd1);
    chk("br_flush2", 32'(FlushID_EX), 32'd1);
    tick;
    EX_BranchTaken = 1'b0;
    nop;
    #1;
    chk("br_fcnt",   32'(FlushCount), 32'd1);
    chk("br_scnt",   32'(StallCount), 32'd1);
    chk("br_flush0", 32'(FlushIF_ID), 32'd0);
    tick;

    // lw x7,0(x7) held in ID: stalls every other cycle, 20 stalls total
    drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      #1;
      chk("sat_stall", 32'(Stall), 32'(i % 2));
      tick;
    end
    #1;
    chk("sat_scnt", 32'(StallCount), 32'd15);
    chk("sat_fcnt", 32'(FlushCount), 32'd1);

    // mid-operation reset discards everything
    rst = 1'b1;
    tick;
    rst = 1'b0;
    nop;
    #1;
    chk("rst2_fwda",   32'(ForwardA),   32'd0);
    chk("rst2_fwdb",   32'(ForwardB),   32'd0);
    chk("rst2_stall",  32'(Stall),      32'd0);
    chk("rst2_flush1", 32'(FlushIF_ID), 32'd0);
    chk("rst2_flush2", 32'(FlushID_EX), 32'd0);
    chk("rst2_scnt",   32'(StallCount), 32'd0);
    chk("rst2_fcnt",   32'(FlushCount), 32'd0);
    drive(1'b1, 5'd7, 5'd7, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    nop;
    #1;
    chk("rst2_nofwd_a", 32'(ForwardA), 32'd0);
    chk("rst2_nofwd_b", 32'(ForwardB), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
